// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage and the data memory: a req/ack
// handshake with word-aligned address, byte enables and replicated write data.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage behind the execute ALU: runs one req/ack bus transaction per
// aligned memory opcode (3..11), stalls upstream meanwhile, and registers
// non-memory results straight through to writeback.
module mem_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bubble,
    input  logic [4:0]         in_op,
    input  logic               in_is_load,
    input  logic [31:0]        in_result,
    input  logic [31:0]        in_store_data,
    input  logic [4:0]         in_tgt,
    output logic               stall_out,
    mem_stage_if.master        bus,
    output logic               wb_valid,
    output logic [4:0]         wb_tgt,
    output logic [31:0]        wb_data,
    output logic               exc_misaligned
);
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_DOUBLE, SZ_BYTE} size_t;

    state_t      state_q, state_d;
    size_t       size_q, size_d, in_size;
    logic [1:0]  off_q, off_d;
    logic [4:0]  tgt_q, tgt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_tgt_q, wb_tgt_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_q, exc_d;
    logic        accept, is_mem, misaligned, start;

    function automatic logic [3:0] steer_be(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_DOUBLE: steer_be = 4'b0011 << off;
            SZ_BYTE:   steer_be = 4'b0001 << off;
            default:   steer_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] steer_wdata(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_DOUBLE: steer_wdata = {2{d[15:0]}};
            SZ_BYTE:   steer_wdata = {4{d[7:0]}};
            default:   steer_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input size_t sz, input logic [1:0] off,
                                                 input logic [31:0] r);
        case (sz)
            SZ_DOUBLE: extract_load = {16'h0, off[1] ? r[31:16] : r[15:0]};
            SZ_BYTE:   extract_load = {24'h0, r[8*off +: 8]};
            default:   extract_load = r;
        endcase
    endfunction

    always_comb begin
        is_mem  = (in_op >= 5'd3) && (in_op <= 5'd11);
        in_size = SZ_WORD;
        case (in_op)
            5'd4, 5'd7, 5'd10: in_size = SZ_DOUBLE;
            5'd5, 5'd8, 5'd11: in_size = SZ_BYTE;
            default:           in_size = SZ_WORD;
        endcase
        case (in_size)
            SZ_WORD:   misaligned = (in_result[1:0] != 2'b00);
            SZ_DOUBLE: misaligned = in_result[0];
            default:   misaligned = 1'b0;
        endcase
        accept    = (state_q == IDLE) && in_valid && !in_bubble;
        start     = accept && is_mem && !misaligned;
        // Upstream is released on the ack cycle so the next instruction lines up with IDLE.
        stall_out = start || ((state_q == BUSY) && !bus.mem_ack);
    end

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        off_d       = off_q;
        tgt_d       = tgt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wb_valid_d  = 1'b0;
        wb_tgt_d    = wb_tgt_q;
        wb_data_d   = wb_data_q;
        exc_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_tgt_d   = in_tgt;
                    wb_data_d  = in_result;
                end else if (accept && misaligned) begin
                    exc_d = 1'b1;
                end else if (start) begin
                    state_d     = BUSY;
                    size_d      = in_size;
                    off_d       = in_result[1:0];
                    tgt_d       = in_tgt;
                    mem_req_d   = 1'b1;
                    mem_we_d    = !in_is_load;
                    mem_addr_d  = {in_result[31:2], 2'b00};
                    mem_be_d    = steer_be(in_size, in_result[1:0]);
                    mem_wdata_d = steer_wdata(in_size, in_store_data);
                end
            end
            default: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_tgt_d   = tgt_q;
                        wb_data_d  = extract_load(size_q, off_q, bus.mem_rdata);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            tgt_q       <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            wb_valid_q  <= 1'b0;
            wb_tgt_q    <= 5'd0;
            wb_data_q   <= 32'h0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            off_q       <= off_d;
            tgt_q       <= tgt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wb_valid_q  <= wb_valid_d;
            wb_tgt_q    <= wb_tgt_d;
            wb_data_q   <= wb_data_d;
            exc_q       <= exc_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_be      = mem_be_q;
    assign wb_valid        = wb_valid_q;
    assign wb_tgt          = wb_tgt_q;
    assign wb_data         = wb_data_q;
    assign exc_misaligned  = exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instructions checked
// against a byte-level reference model of steering, extraction and alignment.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_bubble = 1'b0, in_is_load = 1'b0;
    logic [4:0]  in_op = 5'd0, in_tgt = 5'd0;
    logic [31:0] in_result = 32'h0, in_store_data = 32'h0;
    logic        stall_out, wb_valid, exc_misaligned;
    logic [4:0]  wb_tgt;
    logic [31:0] wb_data;
    int          checks = 0;
    int          errors = 0;

    mem_stage_if bus();

    mem_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bubble(in_bubble),
        .in_op(in_op), .in_is_load(in_is_load), .in_result(in_result),
        .in_store_data(in_store_data), .in_tgt(in_tgt), .stall_out(stall_out),
        .bus(bus), .wb_valid(wb_valid), .wb_tgt(wb_tgt), .wb_data(wb_data),
        .exc_misaligned(exc_misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes from the opcode.
    function automatic int nbytes(input logic [4:0] op);
        int r;
        r = (int'(op) - 3) % 3;
        return (r == 0) ? 4 : (r == 1) ? 2 : 1;
    endfunction

    function automatic logic [3:0] model_be(input logic [4:0] op, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(op)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [4:0] op, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(op);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] r);
        int n;
        n = nbytes(op);
        if (n == 4) return r;
        return (r >> (8 * (a % 4))) & ((n == 2) ? 32'h0000FFFF : 32'h000000FF);
    endfunction

    task automatic present(input logic [4:0] op, input logic ld, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] t);
        in_valid = 1'b1; in_bubble = 1'b0; in_op = op; in_is_load = ld;
        in_result = a; in_store_data = d; in_tgt = t;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        present(5'd3, 1'b1, 32'h100, 32'h55, 5'd4);
        tick; tick;
        checks++;
        if ({bus.mem_req, bus.mem_we, wb_valid, exc_misaligned} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000",
                               {bus.mem_req, bus.mem_we, wb_valid, exc_misaligned});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_be, wb_tgt, wb_data} !== 105'h0) begin
            errors++; $display("FAIL reset_data got addr %h wdata %h be %h tgt %h data %h want 0",
                               bus.mem_addr, bus.mem_wdata, bus.mem_be, wb_tgt, wb_data);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_word_load;
        present(5'd3, 1'b1, 32'h100, 32'h0, 5'd7);
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL wl_stall_accept got %b want 1", stall_out); end
        tick;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
            errors++; $display("FAIL wl_req got req %b we %b addr %h be %b want 1 0 100 1111",
                               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL wl_stall_ack got %b want 0", stall_out); end
        tick;
        bus.mem_ack = 1'b0; in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, wb_valid, wb_tgt, wb_data} !== {1'b0, 1'b1, 5'd7, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wl_wb got req %b vld %b tgt %0d data %h want 0 1 7 deadbeef",
                               bus.mem_req, wb_valid, wb_tgt, wb_data);
        end
        tick;
    endtask

    task automatic test_byte_store;
        present(5'd5, 1'b0, 32'h203, 32'h000000A5, 5'd2);
        tick;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
            {1'b1, 1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5}) begin
            errors++; $display("FAIL bs_req got req %b we %b addr %h be %b wdata %h want 1 1 200 1000 a5a5a5a5",
                               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        tick;
        bus.mem_ack = 1'b0; in_valid = 1'b0;
        checks++;
        if ({bus.mem_req, wb_valid} !== 2'b00) begin
            errors++; $display("FAIL bs_done got req %b vld %b want 0 0", bus.mem_req, wb_valid);
        end
        tick;
    endtask

    task automatic test_double_waits;
        int stall_cnt = 0, req_cnt = 0;
        present(5'd4, 1'b1, 32'h302, 32'h0, 5'd9);
        for (int c = 0; c < 6; c++) begin
            if (c == 4) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234ABCD; end
            #1;
            if (stall_out === 1'b1) stall_cnt++;
            if (bus.mem_req === 1'b1 && bus.mem_addr === 32'h300 && bus.mem_be === 4'b1100) req_cnt++;
            tick;
            if (c == 4) begin bus.mem_ack = 1'b0; in_valid = 1'b0; end
            if (c == 4) begin
                checks++;
                if ({wb_valid, wb_tgt, wb_data} !== {1'b1, 5'd9, 32'h00001234}) begin
                    errors++; $display("FAIL dw_wb got vld %b tgt %0d data %h want 1 9 00001234",
                                       wb_valid, wb_tgt, wb_data);
                end
            end
        end
        checks++;
        if (stall_cnt != 4) begin errors++; $display("FAIL dw_stall_cycles got %0d want 4", stall_cnt); end
        checks++;
        if (req_cnt != 4) begin errors++; $display("FAIL dw_req_cycles got %0d want 4", req_cnt); end
    endtask

    task automatic test_misaligned;
        present(5'd3, 1'b1, 32'h101, 32'h0, 5'd1);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL mis_stall got %b want 0", stall_out); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({exc_misaligned, wb_valid, bus.mem_req} !== 3'b100) begin
            errors++; $display("FAIL mis_pulse got exc %b vld %b req %b want 1 0 0",
                               exc_misaligned, wb_valid, bus.mem_req);
        end
        tick;
        checks++;
        if (exc_misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle got %b want 0", exc_misaligned); end
    endtask

    task automatic test_reset_mid;
        present(5'd9, 1'b1, 32'h400, 32'h0, 5'd5);
        tick;
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", bus.mem_req); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL rm_idle_stall got %b want 0", stall_out); end
        tick;
        bus.mem_ack = 1'b0;
        checks++;
        if ({wb_valid, bus.mem_req} !== 2'b00) begin
            errors++; $display("FAIL rm_late_ack got vld %b req %b want 0 0", wb_valid, bus.mem_req);
        end
    endtask

    task automatic test_passthrough_bubble;
        present(5'd22, 1'b0, 32'h44, 32'h0, 5'd3);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL pt_stall got %b want 0", stall_out); end
        tick;
        in_bubble = 1'b1;
        checks++;
        if ({wb_valid, wb_tgt, wb_data} !== {1'b1, 5'd3, 32'h44}) begin
            errors++; $display("FAIL pt_wb got vld %b tgt %0d data %h want 1 3 44", wb_valid, wb_tgt, wb_data);
        end
        tick;
        in_valid = 1'b0; in_bubble = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL pt_bubble got %b want 0", wb_valid); end
        tick;
    endtask

    task automatic test_random;
        logic [4:0]  op, t;
        logic [31:0] a, d, r, exp_d;
        logic        ld, bub, mem, mis;
        int          waits, n;
        for (int it = 0; it < 80; it++) begin
            op  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 11));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(0, 1) * 2);
            d   = $urandom; r = $urandom; t = 5'($urandom_range(0, 31));
            ld  = 1'($urandom_range(0, 1));
            bub = ($urandom_range(0, 7) == 0);
            waits = $urandom_range(0, 3);
            mem = (op >= 3) && (op <= 11);
            n   = nbytes(op);
            mis = mem && ((a % n) != 0);
            present(op, ld, a, d, t);
            in_bubble = bub;
            #1;
            checks++;
            if (stall_out !== (!bub && mem && !mis)) begin
                errors++; $display("FAIL rnd_stall_accept op %0d got %b want %b", op, stall_out, !bub && mem && !mis);
            end
            tick;
            if (bub || !mem || mis) begin
                in_valid = 1'b0; in_bubble = 1'b0;
                checks++;
                if ({wb_valid, exc_misaligned, bus.mem_req} !== {!bub && !mem, !bub && mis, 1'b0}) begin
                    errors++; $display("FAIL rnd_nomem op %0d got vld %b exc %b req %b want %b %b 0",
                                       op, wb_valid, exc_misaligned, bus.mem_req, !bub && !mem, !bub && mis);
                end
                if (!bub && !mem) begin
                    checks++;
                    if ({wb_tgt, wb_data} !== {t, a}) begin
                        errors++; $display("FAIL rnd_pass got %0d %h want %0d %h", wb_tgt, wb_data, t, a);
                    end
                end
            end else begin
                checks++;
                if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !==
                    {1'b1, !ld, a & 32'hFFFFFFFC, model_be(op, a), model_wdata(op, d)}) begin
                    errors++; $display("FAIL rnd_req op %0d a %h got we %b addr %h be %b wdata %h want %b %h %b %h",
                                       op, a, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                                       !ld, a & 32'hFFFFFFFC, model_be(op, a), model_wdata(op, d));
                end
                for (int w = 0; w < waits; w++) begin
                    in_result = $urandom; in_op = 5'($urandom_range(0, 31));
                    checks++;
                    if ({stall_out, wb_valid, bus.mem_req, bus.mem_addr} !== {1'b1, 1'b0, 1'b1, a & 32'hFFFFFFFC}) begin
                        errors++; $display("FAIL rnd_wait got stall %b vld %b req %b addr %h",
                                           stall_out, wb_valid, bus.mem_req, bus.mem_addr);
                    end
                    tick;
                end
                bus.mem_ack = 1'b1; bus.mem_rdata = r;
                #1;
                checks++;
                if (stall_out !== 1'b0) begin errors++; $display("FAIL rnd_stall_ack got %b want 0", stall_out); end
                tick;
                bus.mem_ack = 1'b0; in_valid = 1'b0;
                exp_d = model_load(op, a, r);
                checks++;
                if ({bus.mem_req, wb_valid} !== {1'b0, ld}) begin
                    errors++; $display("FAIL rnd_done got req %b vld %b want 0 %b", bus.mem_req, wb_valid, ld);
                end
                if (ld) begin
                    checks++;
                    if ({wb_tgt, wb_data} !== {t, exp_d}) begin
                        errors++; $display("FAIL rnd_load op %0d a %h r %h got %0d %h want %0d %h",
                                           op, a, r, wb_tgt, wb_data, t, exp_d);
                    end
                end
            end
            tick;
            checks++;
            if ({wb_valid, exc_misaligned} !== 2'b00) begin
                errors++; $display("FAIL rnd_idle got vld %b exc %b want 0 0", wb_valid, exc_misaligned);
            end
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        test_reset;
        test_word_load;
        test_byte_store;
        test_double_waits;
        test_misaligned;
        test_reset_mid;
        test_passthrough_bubble;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the ALU `result` as the effective address for memory opcodes 3–11 and runs a req/ack transaction on the data bus.
- Handles lane steering and extraction for word, double and byte accesses, and stalls upstream while a transaction is outstanding.
- Non-memory results pass to writeback through one register stage.

Parameters:
- WORD_OPS, 3'b000, reserved (no parameterisation); all widths fixed at 32-bit data, 5-bit opcode and register index.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_bubble  in  1  instruction is a bubble; treated as not valid
- in_op  in  5  major opcode
- in_is_load  in  1  1=load, 0=store (memory opcodes only)
- in_result  in  32  ALU result: effective address for ops 3–11, writeback value otherwise
- in_store_data  in  32  store source register value
- in_tgt  in  5  destination register index
- stall_out  out  1  upstream must hold its outputs this cycle
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  replicated store data
- mem_be  out  4  byte enables, bit0 = byte at offset 0 (little-endian)
- mem_ack  in  1  bus completes the transaction this cycle; mem_rdata is valid
- mem_rdata  in  32  read data
- wb_valid  out  1  writeback entry valid
- wb_tgt  out  5  writeback register
- wb_data  out  32  writeback value
- exc_misaligned  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, wb_valid and exc_misaligned = 0; mem_addr, mem_wdata, mem_be, wb_tgt and wb_data = 0. Reset mid-transaction aborts immediately: mem_req is 0 after the reset edge, and any later ack is ignored.
- Accept condition: state==IDLE && in_valid && !in_bubble.
- Size decode for ops 3–11: (op−3) mod 3.
  - 0 = word: ops 3, 6, 9.
  - 1 = double: ops 4, 7, 10.
  - 2 = byte: ops 5, 8, 11.
- Alignment rules:
  - Word is misaligned if addr[1:0]≠0.
  - Double is misaligned if addr[0]≠0.
  - Byte is always aligned.
- Non-memory accept: registered pass-through; next cycle wb_valid=1, wb_tgt=in_tgt, wb_data=in_result. Latency 1. stall_out=0.
- Misaligned memory accept:
  - No bus request.
  - Next cycle: exc_misaligned=1 and wb_valid=0.
  - stall_out=0.
- Aligned memory accept (IDLE→BUSY):
  - stall_out=1 in the accept cycle; request fields are latched at the edge.
  - mem_req=1 from the next cycle.
  - Field values:
    - mem_we = !in_is_load.
    - mem_addr = word-aligned address.
    - mem_be: word 4'b1111; double 4'b0011<<addr[1:0]; byte 4'b0001<<addr[1:0].
    - mem_wdata: word = data; double = {2{data[15:0]}}; byte = {4{data[7:0]}}.
- BUSY state:
  - Inputs are ignored; request fields are stable.
  - stall_out = !mem_ack.
  - wb_valid=0 each cycle without ack.
  - mem_ack may arrive in the first BUSY cycle (zero wait states).
- On the mem_ack edge, the stage returns to IDLE and mem_req drops.
  - Load: wb_valid=1, wb_tgt = latched tgt.
    - wb_data for a double is zero-extended rdata halfword at offset addr[1].
    - wb_data for a byte is zero-extended rdata byte at offset addr[1:0].
  - Store: wb_valid=0.
- Upstream's held instruction is consumed at the ack edge (stall_out=0 that cycle), so the next instruction is presented in the first IDLE cycle.
- Minimum load latency is 2 cycles from presentation to wb_valid.
- A load to tgt 0 still performs the bus access; wb_valid=1 with tgt 0.
- mem_ack while IDLE is ignored.
- exc_misaligned is high for exactly one cycle per misaligned instruction.
- Address arithmetic: no wrap handling needed; the 32-bit address is used as-is.

Test Plan:
- Word load: op=3, load, addr=0x100, ack on the first BUSY cycle with rdata=0xDEADBEEF → mem_req for 1 cycle, mem_addr=0x100, be=1111, then wb_valid=1, wb_data=0xDEADBEEF. stall_out is high for 1 cycle, i.e. only the accept cycle, because it is 0 in the ack cycle.
- Byte store: op=5, store, addr=0x203, data=0x000000A5 → mem_addr=0x200, be=1000, wdata=0xA5A5A5A5, mem_we=1, wb_valid=0 after ack.
- Double load with 3 wait states: op=4, addr=0x302, rdata=0x1234ABCD on ack → stall_out high for 4 cycles, mem_req stable for 4 cycles, wb_data=0x00001234.
- Misaligned: op=3, addr=0x101 → no mem_req, exc_misaligned pulses 1 cycle, wb_valid=0, no stall.
- Reset mid-transaction: rst during BUSY, then mem_ack arrives → mem_req=0 after the reset edge, state IDLE, late ack produces no wb_valid.
- Pass-through and bubble: op=22, in_result=0x44, then in_bubble=1 → wb_valid=1/wb_data=0x44, then wb_valid=0.
